// File: rtl/ili9341_init_sequencer.sv
// Power-up sequencer for the ILI9341: pulses lcd_rst, then shifts a fixed command/data
// list out over 4-wire SPI with the required waits, and finally raises a sticky done.
module ili9341_init_sequencer #(
  parameter int unsigned RST_LOW_CYCLES  = 200,
  parameter int unsigned RST_WAIT_CYCLES = 1200000,
  parameter int unsigned SWRESET_WAIT    = 1200000,
  parameter int unsigned SLPOUT_WAIT     = 1200000,
  parameter logic [7:0]  COLMOD          = 8'h55,
  parameter logic [7:0]  MADCTL          = 8'h48,
  parameter int          CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  output logic bl,
  output logic lcd_rst,
  output logic dc,
  output logic cs,
  output logic din,
  output logic done
);

  localparam logic [2:0] S_RST_LOW  = 3'd0;
  localparam logic [2:0] S_RST_WAIT = 3'd1;
  localparam logic [2:0] S_FETCH    = 3'd2;
  localparam logic [2:0] S_LOAD     = 3'd3;
  localparam logic [2:0] S_SHIFT    = 3'd4;
  localparam logic [2:0] S_DELAY    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  localparam logic [1:0] T_CMD   = 2'd0;
  localparam logic [1:0] T_DATA  = 2'd1;
  localparam logic [1:0] T_DELAY = 2'd2;
  localparam logic [1:0] T_END   = 2'd3;

  // DELAY entries carry a selector in their byte field: 0 = SWRESET wait, else SLPOUT wait.
  function automatic logic [9:0] rom(input logic [3:0] addr);
    case (addr)
      4'd0:    rom = {T_CMD,   8'h01};
      4'd1:    rom = {T_DELAY, 8'h00};
      4'd2:    rom = {T_CMD,   8'h11};
      4'd3:    rom = {T_DELAY, 8'h01};
      4'd4:    rom = {T_CMD,   8'h3A};
      4'd5:    rom = {T_DATA,  COLMOD};
      4'd6:    rom = {T_CMD,   8'h36};
      4'd7:    rom = {T_DATA,  MADCTL};
      4'd8:    rom = {T_CMD,   8'h29};
      default: rom = {T_END,   8'h00};
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] delay_len(input logic [7:0] sel);
    delay_len = (sel == 8'h00) ? CNT_W'(SWRESET_WAIT) : CNT_W'(SLPOUT_WAIT);
  endfunction

  logic [2:0]       state_q, state_d;
  logic [3:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sel_q, sel_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       idx_q, idx_d;
  logic             lcd_rst_q, lcd_rst_d;
  logic             cs_q, cs_d;
  logic             dc_q, dc_d;
  logic             din_q, din_d;
  logic             bl_q, bl_d;
  logic             done_q, done_d;

  logic [9:0] entry_a, entry;
  logic [3:0] ptr_next;
  logic       skip;
  logic       do_fetch;

  // A zero-length delay is folded into the fetch so it costs no edge.
  always_comb begin
    entry_a  = rom(ptr_q);
    skip     = (entry_a[9:8] == T_DELAY) && (delay_len(entry_a[7:0]) == '0);
    entry    = skip ? rom(ptr_q + 4'd1) : entry_a;
    ptr_next = skip ? ptr_q + 4'd2 : ptr_q + 4'd1;
    do_fetch = (state_q == S_FETCH)
            || ((state_q == S_RST_WAIT) && (cnt_q == CNT_W'(RST_WAIT_CYCLES)))
            || ((state_q == S_DELAY)    && (cnt_q == delay_len(sel_q)));
  end

  always_comb begin
    // NOTE: every _d starts as its _q so no path through this block infers a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    sh_d      = sh_q;
    idx_d     = idx_q;
    lcd_rst_d = lcd_rst_q;
    cs_d      = cs_q;
    dc_d      = dc_q;
    din_d     = din_q;
    bl_d      = bl_q;
    done_d    = done_q;

    case (state_q)
      S_RST_LOW: begin
        if (cnt_q == CNT_W'(RST_LOW_CYCLES)) begin
          lcd_rst_d = 1'b1;
          state_d   = S_RST_WAIT;
          cnt_d     = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RST_WAIT, S_DELAY: begin
        cs_d  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_LOAD, S_SHIFT: begin
        cs_d    = 1'b0;
        din_d   = sh_q[idx_q];
        idx_d   = idx_q - 3'd1;
        state_d = (idx_q == 3'd0) ? S_FETCH : S_SHIFT;
      end
      default: ;
    endcase

    if (do_fetch) begin
      case (entry[9:8])
        T_CMD, T_DATA: begin
          cs_d    = 1'b1;
          dc_d    = (entry[9:8] == T_DATA);
          sh_d    = entry[7:0];
          idx_d   = 3'd7;
          ptr_d   = ptr_next;
          state_d = S_LOAD;
        end
        T_DELAY: begin
          cs_d    = 1'b1;
          sel_d   = entry[7:0];
          cnt_d   = CNT_W'(1);
          ptr_d   = ptr_next;
          state_d = S_DELAY;
        end
        default: begin
          cs_d    = 1'b1;
          bl_d    = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      endcase
    end
  end

  // Falling-edge registers so the panel samples a settled din on the rising edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q   <= S_RST_LOW;
      ptr_q     <= '0;
      cnt_q     <= '0;
      sel_q     <= '0;
      sh_q      <= '0;
      idx_q     <= '0;
      lcd_rst_q <= 1'b0;
      cs_q      <= 1'b1;
      dc_q      <= 1'b0;
      din_q     <= 1'b0;
      bl_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      sh_q      <= sh_d;
      idx_q     <= idx_d;
      lcd_rst_q <= lcd_rst_d;
      cs_q      <= cs_d;
      dc_q      <= dc_d;
      din_q     <= din_d;
      bl_q      <= bl_d;
      done_q    <= done_d;
    end
  end

  assign bl      = bl_q;
  assign lcd_rst = lcd_rst_q;
  assign dc      = dc_q;
  assign cs      = cs_q;
  assign din     = din_q;
  assign done    = done_q;

endmodule

// File: tb/tb_ili9341_init_sequencer.sv
// Directed bench: three sequencer instances (baseline, data-byte overrides, zero SWRESET
// wait) share clk/rst; per-edge traces and rising-edge SPI captures are checked per scenario.
module tb_ili9341_init_sequencer;

  logic       clk = 1'b1;
  logic       rst = 1'b1;
  logic [2:0] bl_w, lcd_rst_w, dc_w, cs_w, din_w, done_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ili9341_init_sequencer #(
    .RST_LOW_CYCLES(4), .RST_WAIT_CYCLES(3), .SWRESET_WAIT(5), .SLPOUT_WAIT(6)
  ) dut_a (
    .clk(clk), .rst(rst), .bl(bl_w[0]), .lcd_rst(lcd_rst_w[0]), .dc(dc_w[0]),
    .cs(cs_w[0]), .din(din_w[0]), .done(done_w[0])
  );

  ili9341_init_sequencer #(
    .RST_LOW_CYCLES(4), .RST_WAIT_CYCLES(3), .SWRESET_WAIT(5), .SLPOUT_WAIT(6),
    .COLMOD(8'h66), .MADCTL(8'h08)
  ) dut_b (
    .clk(clk), .rst(rst), .bl(bl_w[1]), .lcd_rst(lcd_rst_w[1]), .dc(dc_w[1]),
    .cs(cs_w[1]), .din(din_w[1]), .done(done_w[1])
  );

  ili9341_init_sequencer #(
    .RST_LOW_CYCLES(4), .RST_WAIT_CYCLES(3), .SWRESET_WAIT(0), .SLPOUT_WAIT(6)
  ) dut_c (
    .clk(clk), .rst(rst), .bl(bl_w[2]), .lcd_rst(lcd_rst_w[2]), .dc(dc_w[2]),
    .cs(cs_w[2]), .din(din_w[2]), .done(done_w[2])
  );

  // Per-edge traces, index = edge number after reset release.
  logic tr_cs[3][256], tr_dc[3][256], tr_din[3][256];
  logic tr_rst[3][256], tr_done[3][256], tr_bl[3][256];

  // Rising-edge SPI capture while cs=0.
  int         nbits[3];
  logic [7:0] sr[3];
  logic [7:0] cap_byte[3][8];
  logic       cap_dc[3][8];

  logic [7:0] exp_bytes[7] = '{8'h01, 8'h11, 8'h3A, 8'h55, 8'h36, 8'h48, 8'h29};
  logic       exp_dc[7]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  task automatic clear_capture();
    for (int k = 0; k < 3; k++) begin
      nbits[k] = 0;
      sr[k]    = 8'h00;
      for (int j = 0; j < 8; j++) begin
        cap_byte[k][j] = 8'h00;
        cap_dc[k][j]   = 1'b0;
      end
    end
  endtask

  task automatic run_edges(input int n);
    logic [7:0] nb;
    for (int e = 1; e <= n; e++) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        tr_cs[k][e]   = cs_w[k];
        tr_dc[k][e]   = dc_w[k];
        tr_din[k][e]  = din_w[k];
        tr_rst[k][e]  = lcd_rst_w[k];
        tr_done[k][e] = done_w[k];
        tr_bl[k][e]   = bl_w[k];
      end
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
        if (cs_w[k] == 1'b0) begin
          nb    = {sr[k][6:0], din_w[k]};
          sr[k] = nb;
          if ((nbits[k] % 8) == 7 && (nbits[k] / 8) < 8) begin
            cap_byte[k][nbits[k] / 8] = nb;
            cap_dc[k][nbits[k] / 8]   = dc_w[k];
          end
          nbits[k] = nbits[k] + 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({lcd_rst_w[k], cs_w[k], dc_w[k], din_w[k], bl_w[k], done_w[k]} !== 6'b010000) begin
        bad++;
        $display("FAIL reset_values dut%0d: got rst/cs/dc/din/bl/done=%b want 010000", k,
                 {lcd_rst_w[k], cs_w[k], dc_w[k], din_w[k], bl_w[k], done_w[k]});
      end
    end
    rst = 1'b0;
  endtask

  // Baseline instance: reset pulse, wait, LOAD on edge 8 and 0x01 shifted on edges 9..16.
  task automatic test_release_timing(input string tag);
    logic [7:0] b;
    b = 8'h01;
    for (int e = 1; e <= 16; e++) begin
      logic [2:0] got, want;
      got = {tr_rst[0][e], tr_cs[0][e], (e >= 9) ? tr_din[0][e] : tr_dc[0][e]};
      if (e <= 4)      want = {1'b0, 1'b1, 1'b0};
      else if (e <= 8) want = {1'b1, 1'b1, 1'b0};
      else             want = {1'b1, 1'b0, b[16 - e]};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s edge %0d: got lcd_rst/cs/(dc|din)=%b want %b", tag, e, got, want);
      end
    end
  endtask

  task automatic test_capture();
    for (int j = 0; j < 7; j++) begin
      logic [7:0] wb;
      wb = exp_bytes[j];
      total++;
      if (cap_byte[0][j] !== wb || cap_dc[0][j] !== exp_dc[j]) begin
        bad++;
        $display("FAIL capture byte %0d: got %h dc=%b want %h dc=%b", j, cap_byte[0][j],
                 cap_dc[0][j], wb, exp_dc[j]);
      end
    end
    total++;
    if (nbits[0] !== 56) begin
      bad++;
      $display("FAIL capture bit_count: got %0d want 56", nbits[0]);
    end
  endtask

  task automatic test_delay_timing();
    logic [7:0] b;
    b = 8'h29;
    for (int e = 17; e <= 22; e++) begin
      total++;
      if (tr_cs[0][e] !== 1'b1) begin
        bad++;
        $display("FAIL swreset_wait edge %0d: got cs=%b want 1", e, tr_cs[0][e]);
      end
    end
    total++;
    if (tr_cs[0][23] !== 1'b0 || tr_dc[0][22] !== 1'b0) begin
      bad++;
      $display("FAIL slpout_load edge 22/23: got cs23=%b dc22=%b want 0 0", tr_cs[0][23],
               tr_dc[0][22]);
    end
    for (int e = 31; e <= 37; e++) begin
      total++;
      if (tr_cs[0][e] !== 1'b1) begin
        bad++;
        $display("FAIL slpout_wait edge %0d: got cs=%b want 1", e, tr_cs[0][e]);
      end
    end
    total++;
    if (tr_cs[0][30] !== 1'b0 || tr_cs[0][38] !== 1'b0) begin
      bad++;
      $display("FAIL slpout_bounds: got cs30=%b cs38=%b want 0 0", tr_cs[0][30], tr_cs[0][38]);
    end
    for (int e = 74; e <= 81; e++) begin
      total++;
      if (tr_cs[0][e] !== 1'b0 || tr_din[0][e] !== b[81 - e]) begin
        bad++;
        $display("FAIL dispon_shift edge %0d: got cs=%b din=%b want 0 %b", e, tr_cs[0][e],
                 tr_din[0][e], b[81 - e]);
      end
    end
  endtask

  task automatic test_done();
    total++;
    if (tr_done[0][81] !== 1'b0 || tr_done[0][82] !== 1'b1 || tr_bl[0][82] !== 1'b1) begin
      bad++;
      $display("FAIL done_edge: got done81=%b done82=%b bl82=%b want 0 1 1", tr_done[0][81],
               tr_done[0][82], tr_bl[0][82]);
    end
    for (int e = 83; e <= 182; e++) begin
      total++;
      if (tr_cs[0][e] !== 1'b1 || tr_done[0][e] !== 1'b1 || tr_bl[0][e] !== 1'b1 ||
          tr_din[0][e] !== 1'b1) begin
        bad++;
        $display("FAIL done_frozen edge %0d: got cs/done/bl/din=%b%b%b%b want 1111", e,
                 tr_cs[0][e], tr_done[0][e], tr_bl[0][e], tr_din[0][e]);
      end
    end
  endtask

  task automatic test_overrides();
    logic [7:0] b;
    total++;
    if (cap_byte[1][3] !== 8'h66 || cap_byte[1][5] !== 8'h08) begin
      bad++;
      $display("FAIL colmod_madctl: got %h %h want 66 08", cap_byte[1][3], cap_byte[1][5]);
    end
    b = 8'h11;
    total++;
    if (tr_cs[2][16] !== 1'b0 || tr_cs[2][17] !== 1'b1 || tr_dc[2][17] !== 1'b0) begin
      bad++;
      $display("FAIL zero_wait_load: got cs16=%b cs17=%b dc17=%b want 0 1 0", tr_cs[2][16],
               tr_cs[2][17], tr_dc[2][17]);
    end
    for (int e = 18; e <= 25; e++) begin
      total++;
      if (tr_cs[2][e] !== 1'b0 || tr_din[2][e] !== b[25 - e]) begin
        bad++;
        $display("FAIL zero_wait_shift edge %0d: got cs=%b din=%b want 0 %b", e,
                 tr_cs[2][e], tr_din[2][e], b[25 - e]);
      end
    end
    total++;
    if (tr_done[2][76] !== 1'b0 || tr_done[2][77] !== 1'b1) begin
      bad++;
      $display("FAIL zero_wait_done: got done76=%b done77=%b want 0 1", tr_done[2][76],
               tr_done[2][77]);
    end
  endtask

  // Reset on the third SHIFT edge of 0x3A (edge 40), then restart from scratch.
  task automatic test_mid_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    clear_capture();
    run_edges(40);
    total++;
    if (tr_cs[0][40] !== 1'b0 || tr_cs[0][37] !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_position: got cs37=%b cs40=%b want 1 0", tr_cs[0][37],
               tr_cs[0][40]);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (cs_w[0] !== 1'b1 || lcd_rst_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_values: got cs=%b lcd_rst=%b done=%b want 1 0 0", cs_w[0],
               lcd_rst_w[0], done_w[0]);
    end
    rst = 1'b0;
    clear_capture();
    run_edges(20);
    test_release_timing("restart_timing");
    total++;
    if (nbits[0] < 8 || cap_byte[0][0] !== 8'h01) begin
      bad++;
      $display("FAIL restart_first_byte: got %h (%0d bits) want 01", cap_byte[0][0], nbits[0]);
    end
  endtask

  initial begin
    clear_capture();
    test_reset();
    run_edges(190);
    test_release_timing("release_timing");
    test_capture();
    test_delay_timing();
    test_done();
    test_overrides();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
